mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Shares the single-ported memory between instruction fetch and the data-memory accesses of the MIPS datapath (lw, lbu, sw, sb, addm).
- Holds one transaction in flight at a time and latches the address and write data on grant.
- Returns the read data to the owning requester and drives the PC/pipeline stall while any request is outstanding.
- Sits between the fetch unit and decoder-driven memory controls (mem_read, word_we, byte_we) on one side and the memory on the other.

Parameters:
- MAX_DATA_RUN, 4: maximum consecutive data grants while fetch waits; range 1..15.
- TIMEOUT, 64: BUSY cycles without mem_ready before abort. Used only with MEM_TIMEOUT_EN; range 2..255.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  fetch request; held high and stable until if_done
- if_addr  in  32  fetch word address
- if_rdata  out  32  fetched instruction, registered
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held high and stable until d_done
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_word_we  in  1  word store (sw)
- d_byte_we  in  1  byte store (sb)
- d_rdata  out  32  load data, registered
- d_done  out  1  one-cycle data completion pulse
- mem_req  out  1  memory access valid
- mem_addr  out  32  latched address
- mem_wdata  out  32  latched store data
- mem_word_we  out  1  latched word write enable
- mem_byte_we  out  1  latched byte write enable
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, any cycle in BUSY
- stall  out  1  hold PC/pipeline
- bus_error  out  1  one-cycle timeout pulse, coincident with done

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. mem_req, all we, if_done, d_done, bus_error=0. if_rdata, d_rdata, mem_addr, mem_wdata, run counter=0. Reset mid-transaction aborts it with no done pulse.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE, no request: remain.
- IDLE, grant data: d_req=1 and (if_req=0 or run<MAX_DATA_RUN) -> latch d_addr, d_wdata, we bits; go to BUSY_D.
- IDLE, grant fetch: otherwise, if if_req=1 -> latch if_addr, we=0; go to BUSY_I.
- Run counter:
  - Increments (saturating at MAX_DATA_RUN) on a data grant while if_req=1.
  - Clears on a fetch grant, and on a data grant while if_req=0.
- d_word_we and d_byte_we both 1: word store; mem_byte_we=0.
- BUSY_x:
  - mem_req=1; outputs stable.
  - mem_ready=1 -> go to RESP_x. For reads, capture mem_rdata into if_rdata or d_rdata; stores leave d_rdata unchanged.
- RESP_x: done_x=1 for exactly this cycle; mem_req=0; go to IDLE.
- Requester contract: drop or change req only after the edge that ends its done cycle. No back-to-back grant to the same requester without an IDLE cycle.
- Minimum latency: request seen in IDLE at cycle 0; mem_req cycle 1 with ready; done cycle 2; IDLE cycle 3.
- mem_ready in IDLE or RESP is ignored.
- stall = (if_req & ~if_done) | (d_req & ~d_done), combinational.
- The unowned rdata register holds its value throughout.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter clears on BUSY entry and increments each BUSY cycle without mem_ready.
  - At count TIMEOUT-1 with no ready: go to RESP_x; done and bus_error pulse together; rdata unchanged; run counter unaffected.
  - mem_ready in the same cycle as expiry wins (normal completion).
- Undefined: BUSY waits indefinitely; bus_error tied 0.

Test Plan:
- Fetch only: if_req=1, if_addr=0x00400000, mem_ready the cycle after mem_req with rdata 0x20080005 -> mem_addr=0x00400000, if_done at cycle 2, if_rdata=0x20080005, stall low at cycle 3.
- Simultaneous requests, MAX_DATA_RUN=2: data requests issued back-to-back with if_req held -> grants D, D, I, D; run counter clears after the fetch grant.
- sb at 0x10010003, wdata 0xAB, both we=1 -> mem_word_we=1, mem_byte_we=0; d_rdata keeps its prior 0x12345678.
- Memory wait of 5 cycles -> mem_req high 5 cycles with stable addr/wdata; single done pulse; stall high throughout.
- Reset pulsed low during BUSY_D -> mem_req drops immediately, no d_done; after release, a new request is granted normally.
- MEM_TIMEOUT_EN, TIMEOUT=8, mem_ready never asserted -> d_done and bus_error at the 9th cycle after grant; MEM_TIMEOUT_EN off -> remains BUSY after 100 cycles, bus_error=0.

Source files
------------

// File: rtl/mips_mem_arbiter_if.sv
// Signal bundle between mips_mem_arbiter, the fetch/data requesters and the memory.
// master is the arbiter's view; slave is the view of the requesters and memory together.
interface mips_mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_req;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_word_we;
   logic        d_byte_we;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_word_we;
   logic        mem_byte_we;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall;
   logic        bus_error;

   modport master (
      input  if_req, if_addr, d_req, d_addr, d_wdata, d_word_we, d_byte_we,
             mem_rdata, mem_ready,
      output if_rdata, if_done, d_rdata, d_done, mem_req, mem_addr, mem_wdata,
             mem_word_we, mem_byte_we, stall, bus_error
   );

   modport slave (
      output if_req, if_addr, d_req, d_addr, d_wdata, d_word_we, d_byte_we,
             mem_rdata, mem_ready,
      input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_addr, mem_wdata,
             mem_word_we, mem_byte_we, stall, bus_error
   );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-ported memory arbiter between MIPS instruction fetch and data accesses.
// Define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT cycles without mem_ready.
module mips_mem_arbiter #(
   parameter int unsigned MAX_DATA_RUN = 4,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic               clock,
   input  logic               reset,
   mips_mem_arbiter_if.master bus
);
   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_e;

   localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

   if (MAX_DATA_RUN < 1 || MAX_DATA_RUN > 15 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
      $error("mips_mem_arbiter: MAX_DATA_RUN or TIMEOUT out of range");
   end

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        word_we_q, word_we_d;
   logic        byte_we_q, byte_we_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic [3:0]  run_q, run_d;
   logic        busy, data_grant, expire, if_done, d_done;

   assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);
   // Data wins unless fetch has already watched MAX_DATA_RUN data grants in a row.
   assign data_grant = bus.d_req && (!bus.if_req || (run_q < RUN_MAX));

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wait_q, wait_d;
   logic       err_q, err_d;

   // A ready in the expiry cycle still completes normally.
   assign expire = busy && !bus.mem_ready && (wait_q == WAIT_LAST);

   always_comb begin
      wait_d = wait_q;
      err_d  = expire;
      if (state_q == IDLE) begin
         wait_d = '0;
      end else if (busy && !bus.mem_ready) begin
         wait_d = wait_q + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wait_q <= wait_d;
         err_q  <= err_d;
      end
   end

   assign bus.bus_error = err_q;
`else
   assign expire        = 1'b0;
   assign bus.bus_error = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      word_we_d  = word_we_q;
      byte_we_d  = byte_we_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      run_d      = run_q;
      case (state_q)
         IDLE: begin
            if (data_grant) begin
               state_d   = BUSY_D;
               addr_d    = bus.d_addr;
               wdata_d   = bus.d_wdata;
               word_we_d = bus.d_word_we;
               // sw and sb together collapse to a word store
               byte_we_d = bus.d_byte_we & ~bus.d_word_we;
               if (!bus.if_req) begin
                  run_d = '0;
               end else if (run_q != RUN_MAX) begin
                  run_d = run_q + 4'd1;
               end
            end else if (bus.if_req) begin
               state_d   = BUSY_I;
               addr_d    = bus.if_addr;
               word_we_d = 1'b0;
               byte_we_d = 1'b0;
               run_d     = '0;
            end
         end
         BUSY_I: begin
            if (bus.mem_ready) begin
               state_d    = RESP_I;
               if_rdata_d = bus.mem_rdata;
            end else if (expire) begin
               state_d = RESP_I;
            end
         end
         BUSY_D: begin
            if (bus.mem_ready) begin
               state_d = RESP_D;
               if (!word_we_q && !byte_we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
            end else if (expire) begin
               state_d = RESP_D;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_we_q  <= 1'b0;
         byte_we_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         run_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         word_we_q  <= word_we_d;
         byte_we_q  <= byte_we_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         run_q      <= run_d;
      end
   end

   assign if_done         = (state_q == RESP_I);
   assign d_done          = (state_q == RESP_D);
   assign bus.if_done     = if_done;
   assign bus.d_done      = d_done;
   assign bus.mem_req     = busy;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.mem_word_we = word_we_q;
   assign bus.mem_byte_we = byte_we_q;
   assign bus.if_rdata    = if_rdata_q;
   assign bus.d_rdata     = d_rdata_q;
   assign bus.stall       = (bus.if_req & ~if_done) | (bus.d_req & ~d_done);
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomized scoreboard bench for mips_mem_arbiter; optional MEM_TIMEOUT_EN selects the timeout scenario.
module tb_mips_mem_arbiter;
   localparam int MAXR = 2;
   localparam int TO   = 8;
`ifdef MEM_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   typedef struct { bit is_d; logic [31:0] rdata; bit err; int busy; } comp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   mips_mem_arbiter_if bus ();
   mips_mem_arbiter #(.MAX_DATA_RUN(MAXR), .TIMEOUT(TO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] mem [logic [31:0]];
   comp_t       comp_q[$];
   int          streak = 0;
   logic [31:0] last_if = '0;
   logic [31:0] last_d  = '0;
   bit          g_if = 1'b0, g_d = 1'b0;
   int          force_w = -1;
   string       grant_log = "";

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   function automatic int pick_wait();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 12) return r % 3;
      if (r < 18) return int'($urandom_range(3, 6));
      return TO_ON ? 9 + (r % 4) : 7;
   endfunction

   // Request levels as seen by the arbiter at each rising edge.
   initial forever begin
      @(posedge clock);
      g_if = bus.if_req;
      g_d  = bus.d_req;
   end

   // Memory model plus grant checker: decides the expected owner at each new access.
   initial begin : mem_model
      bit          in_acc;
      int          cnt, w;
      bit          exp_d;
      comp_t       c;
      logic [31:0] ea, ew;
      bit          eww, ebw;
      in_acc = 1'b0; cnt = 0; w = 0; eww = 1'b0; ebw = 1'b0; ea = '0; ew = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clock);
         #1;
         if (bus.mem_req === 1'b1) begin
            if (!in_acc) begin
               in_acc = 1'b1;
               cnt    = 0;
               w      = (force_w >= 0) ? force_w : pick_wait();
               chk("grant_has_request", {31'b0, g_if | g_d}, 32'd1);
               exp_d = g_d && (!g_if || streak < MAXR);
               if (exp_d) streak = g_if ? ((streak < MAXR) ? streak + 1 : streak) : 0;
               else streak = 0;
               grant_log = {grant_log, (bus.mem_addr[31:28] == 4'h1) ? "D" : "I"};
               c.is_d = exp_d;
               c.err  = TO_ON && (w >= TO);
               c.busy = c.err ? TO : w + 1;
               if (exp_d) begin
                  ea = bus.d_addr; ew = bus.d_wdata;
                  eww = bus.d_word_we; ebw = bus.d_byte_we & ~bus.d_word_we;
                  c.rdata = (c.err || bus.d_word_we || bus.d_byte_we) ? last_d : memf(bus.d_addr);
                  last_d  = c.rdata;
               end else begin
                  ea = bus.if_addr; ew = bus.mem_wdata; eww = 1'b0; ebw = 1'b0;
                  c.rdata = c.err ? last_if : memf(bus.if_addr);
                  last_if = c.rdata;
               end
               comp_q.push_back(c);
            end
            chk("mem_addr", bus.mem_addr, ea);
            if (exp_d) chk("mem_wdata", bus.mem_wdata, ew);
            chk("mem_word_we", {31'b0, bus.mem_word_we}, {31'b0, eww});
            chk("mem_byte_we", {31'b0, bus.mem_byte_we}, {31'b0, ebw});
            if (cnt == w) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = memf(bus.mem_addr);
            end else begin
               bus.mem_ready = 1'b0;
               bus.mem_rdata = $urandom;
            end
            cnt++;
         end else begin
            in_acc        = 1'b0;
            bus.mem_ready = ($urandom_range(0, 3) == 0);
            bus.mem_rdata = $urandom;
         end
      end
   end

   // Completion monitor: pops the scoreboard on every done pulse.
   initial begin : done_mon
      int    busy_cnt;
      bit    prev_mreq, prev_done, done;
      comp_t c;
      busy_cnt = 0; prev_mreq = 1'b0; prev_done = 1'b0;
      forever begin
         @(negedge clock);
         #1;
         if (reset === 1'b1) begin
            done = bus.if_done | bus.d_done;
            if (bus.if_done && bus.d_done) chk("single_done", 32'd2, 32'd1);
            if (done) begin
               if (comp_q.size() == 0) begin
                  chk("done_expected", 32'd0, 32'd1);
               end else begin
                  c = comp_q.pop_front();
                  chk("done_owner", {31'b0, bus.d_done}, {31'b0, c.is_d});
                  chk("done_rdata", c.is_d ? bus.d_rdata : bus.if_rdata, c.rdata);
                  chk("other_rdata_held", c.is_d ? bus.if_rdata : bus.d_rdata, c.is_d ? last_if : last_d);
                  chk("bus_error", {31'b0, bus.bus_error}, {31'b0, c.err});
                  chk("busy_cycles", busy_cnt, c.busy);
                  chk("done_follows_busy", {30'b0, prev_mreq, bus.mem_req}, 32'd2);
                  chk("stall_done", {31'b0, bus.stall}, {31'b0, c.is_d ? bus.if_req : bus.d_req});
               end
            end else begin
               chk("bus_error_idle", {31'b0, bus.bus_error}, 32'd0);
               chk("stall", {31'b0, bus.stall}, {31'b0, bus.if_req | bus.d_req});
            end
            if (prev_done) chk("idle_after_done", {31'b0, bus.mem_req}, 32'd0);
            busy_cnt  = bus.mem_req ? busy_cnt + 1 : 0;
            prev_mreq = bus.mem_req;
            prev_done = done;
         end else begin
            busy_cnt = 0; prev_mreq = 1'b0; prev_done = 1'b0;
         end
      end
   end

   task automatic wait_done(input bit is_d, output int lat);
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!(is_d ? bus.d_done : bus.if_done) && lat < 400);
      if (!(is_d ? bus.d_done : bus.if_done)) chk(is_d ? "d_done_timeout" : "if_done_timeout", 32'd0, 32'd1);
   endtask

   task automatic fetch_txn(input logic [31:0] a, output int lat);
      bus.if_addr = a;
      bus.if_req  = 1'b1;
      wait_done(1'b0, lat);
      @(negedge clock);
   endtask

   task automatic d_txn(input logic [31:0] a, input logic [31:0] wd, input bit ww, input bit bw, output int lat);
      bus.d_addr = a; bus.d_wdata = wd; bus.d_word_we = ww; bus.d_byte_we = bw;
      bus.d_req  = 1'b1;
      wait_done(1'b1, lat);
      @(negedge clock);
   endtask

   task automatic fetch_thread(input int n);
      int lat;
      for (int i = 0; i < n; i++) begin
         fetch_txn(32'h0040_0000 | ($urandom & 32'h000F_FFFC), lat);
         if ($urandom_range(0, 2) != 0) begin
            bus.if_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clock);
         end
      end
      bus.if_req = 1'b0;
   endtask

   task automatic data_thread(input int n);
      int lat;
      int k;
      for (int i = 0; i < n; i++) begin
         k = int'($urandom_range(0, 3));
         d_txn(32'h1001_0000 | ($urandom & 32'h0000_FFFF), $urandom, k[0], k[1], lat);
         if ($urandom_range(0, 2) != 0) begin
            bus.d_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clock);
         end
      end
      bus.d_req = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin : main
      int lat, lat_f, k;
      bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_addr = '0;
      bus.d_wdata = '0; bus.d_word_we = 1'b0; bus.d_byte_we = 1'b0;
      mem[32'h0040_0000] = 32'h2008_0005;
      mem[32'h1001_1000] = 32'h1234_5678;

      repeat (3) @(negedge clock);
      #2;
      chk("rst_mem_req",   {31'b0, bus.mem_req},     32'd0);
      chk("rst_word_we",   {31'b0, bus.mem_word_we}, 32'd0);
      chk("rst_byte_we",   {31'b0, bus.mem_byte_we}, 32'd0);
      chk("rst_if_done",   {31'b0, bus.if_done},     32'd0);
      chk("rst_d_done",    {31'b0, bus.d_done},      32'd0);
      chk("rst_bus_error", {31'b0, bus.bus_error},   32'd0);
      chk("rst_if_rdata",  bus.if_rdata,  32'd0);
      chk("rst_d_rdata",   bus.d_rdata,   32'd0);
      chk("rst_mem_addr",  bus.mem_addr,  32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_stall",     {31'b0, bus.stall}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // fetch only, zero-wait memory
      force_w = 0;
      fetch_txn(32'h0040_0000, lat);
      chk("fetch_latency", lat, 2);
      chk("fetch_rdata", bus.if_rdata, 32'h2008_0005);
      bus.if_req = 1'b0;
      #1 chk("fetch_stall_low", {31'b0, bus.stall}, 32'd0);
      @(negedge clock);

      // load then sb with both enables
      force_w = -1;
      d_txn(32'h1001_1000, 32'h0, 1'b0, 1'b0, lat);
      bus.d_req = 1'b0;
      chk("load_rdata", bus.d_rdata, 32'h1234_5678);
      d_txn(32'h1001_0003, 32'h0000_00AB, 1'b1, 1'b1, lat);
      bus.d_req = 1'b0;
      chk("store_keeps_rdata", bus.d_rdata, 32'h1234_5678);
      repeat (2) @(negedge clock);

      // contention: fetch gets in after MAX_DATA_RUN data grants
      grant_log = "";
      fork
         begin
            for (int i = 0; i < 2; i++) fetch_txn(32'h0040_0100 + 32'(i * 4), lat_f);
            bus.if_req = 1'b0;
         end
         begin
            for (int i = 0; i < 5; i++) d_txn(32'h1001_0100 + 32'(i * 4), 32'h0, 1'b0, 1'b0, lat);
            bus.d_req = 1'b0;
         end
      join
      n_cmp++;
      if (grant_log != "DDIDDID") begin
         n_bad++;
         $display("FAIL arb_order: got %s expected DDIDDID", grant_log);
      end
      repeat (2) @(negedge clock);

      // memory holds off for several cycles
      force_w = 4;
      d_txn(32'h1001_2000, 32'h0, 1'b0, 1'b0, lat);
      bus.d_req = 1'b0;
      chk("wait5_latency", lat, 6);
      force_w = -1;
      repeat (2) @(negedge clock);

      fork
         fetch_thread(30);
         data_thread(30);
      join
      repeat (3) @(negedge clock);

`ifdef MEM_TIMEOUT_EN
      force_w = 100;
      bus.d_addr = 32'h1001_3000; bus.d_wdata = '0; bus.d_word_we = 1'b0; bus.d_byte_we = 1'b0;
      bus.d_req = 1'b1;
      wait_done(1'b1, lat);
      chk("timeout_latency", lat, 9);
      chk("timeout_bus_error", {31'b0, bus.bus_error}, 32'd1);
      @(negedge clock);
      bus.d_req = 1'b0;
      repeat (2) @(negedge clock);
`else
      force_w = 100000;
      bus.d_addr = 32'h1001_3000; bus.d_wdata = '0; bus.d_word_we = 1'b0; bus.d_byte_we = 1'b0;
      bus.d_req = 1'b1;
      repeat (101) @(negedge clock);
      chk("hang_mem_req", {31'b0, bus.mem_req}, 32'd1);
      chk("hang_bus_error", {31'b0, bus.bus_error}, 32'd0);
`endif

      // reset in the middle of a data access
      force_w = 100000;
      if (!bus.d_req) begin
         bus.d_addr = 32'h1001_4000; bus.d_word_we = 1'b0; bus.d_byte_we = 1'b0;
         bus.d_req = 1'b1;
         k = 0;
         while (!bus.mem_req && k < 20) begin
            @(negedge clock);
            k++;
         end
         repeat (2) @(negedge clock);
      end
      chk("rst_test_busy", {31'b0, bus.mem_req}, 32'd1);
      #3 reset = 1'b0;
      #1;
      chk("abort_mem_req", {31'b0, bus.mem_req}, 32'd0);
      chk("abort_d_done", {31'b0, bus.d_done}, 32'd0);
      chk("abort_d_rdata", bus.d_rdata, 32'd0);
      comp_q.delete();
      last_if = '0; last_d = '0; streak = 0;
      bus.d_req = 1'b0;
      force_w = -1;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      d_txn(32'h1001_1000, 32'h0, 1'b0, 1'b0, lat);
      bus.d_req = 1'b0;
      chk("post_reset_load", bus.d_rdata, 32'h1234_5678);
      fetch_txn(32'h0040_0000, lat);
      bus.if_req = 1'b0;
      chk("post_reset_fetch", bus.if_rdata, 32'h2008_0005);
      repeat (4) @(negedge clock);
      chk("scoreboard_drained", comp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
